// File: rtl/mux41_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux41_rr_arbiter_if
// Description : Bundle of request, source-data and arbitrated-output signals
//               shared between the round-robin 4:1 mux arbiter and its users.
//               master : requesters / environment (drives req, in1..in4)
//               slave  : arbiter (drives select, grant, out, out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface mux41_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;        // bit0=in1 ... bit3=in4
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic [1:0]       select;     // registered mux select
    logic [3:0]       grant;      // registered one-hot grant, 0 when idle
    logic [WIDTH-1:0] out;        // registered muxed data
    logic             out_valid;  // out holds a word from a granted source

    modport master (
        output req, in1, in2, in3, in4,
        input  select, grant, out, out_valid
    );

    modport slave (
        input  req, in1, in2, in3, in4,
        output select, grant, out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux41_rr_arbiter
// Description : Round-robin arbiter that time-shares one 4:1 word mux between
//               four requesters. Registers the select and a one-hot grant and
//               produces a registered, valid-qualified output word.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - mux41_rr_arbiter_if.slave (req, in1..in4 in;
//                      select, grant, out, out_valid out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux41_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4   // >= 1
) (
    input wire                 clk,
    input wire                 rst,
    mux41_rr_arbiter_if.slave  bus
);

    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_sel,   w_sel_nxt;
    logic [1:0]          r_ptr,   w_ptr_nxt;
    logic [3:0]          r_grant, w_grant_nxt;
    logic [c_hold_w-1:0] r_hold,  w_hold_nxt;
    logic [WIDTH-1:0]    r_out;
    logic                r_out_valid;

    // ------------------------------------------------------------------
    // Winner search. The request vector is rotated so that the
    // highest-priority index lands at bit 0, then priority-encoded.
    // While granting, the search starts just past the owner so that the
    // owner itself is considered last.
    // ------------------------------------------------------------------
    logic [1:0] w_base;
    logic [7:0] w_req2;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic [3:0] w_win_oh;
    logic       w_found;

    assign w_base   = (r_state == ST_GRANT) ? (r_sel + 2'd1) : r_ptr;
    assign w_req2   = {bus.req, bus.req};
    assign w_rot    = w_req2[w_base +: 4];
    assign w_win    = w_base + w_off;
    assign w_win_oh = 4'b0001 << w_win;
    assign w_found  = |bus.req;

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Owner status
    // ------------------------------------------------------------------
    logic [3:0] w_sel_oh;
    logic       w_owner_req;
    logic       w_others;
    logic       w_at_cap;
    logic       w_release;

    assign w_sel_oh    = 4'b0001 << r_sel;
    assign w_owner_req = bus.req[r_sel];
    assign w_others    = |(bus.req & ~w_sel_oh);
    assign w_at_cap    = (r_hold == c_hold_max);
    // The owner yields when it stops requesting, or when it has used its
    // full hold budget and somebody else is waiting.
    assign w_release   = ~w_owner_req | (w_at_cap & w_others);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_grant_nxt = w_win_oh;
                    w_hold_nxt  = c_hold_one;
                end
            end

            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 2'd1;
                    if (w_found) begin
                        // Back-to-back hand-over, no idle cycle.
                        w_sel_nxt   = w_win;
                        w_grant_nxt = w_win_oh;
                        w_hold_nxt  = c_hold_one;
                    end else begin
                        // Select deliberately holds its last value.
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else if (!w_at_cap) begin
                    w_hold_nxt = r_hold + c_hold_one;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data mux for the current owner
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_mux;

    always_comb begin
        w_mux = bus.in1;
        case (r_sel)
            2'd0:    w_mux = bus.in1;
            2'd1:    w_mux = bus.in2;
            2'd2:    w_mux = bus.in3;
            2'd3:    w_mux = bus.in4;
            default: w_mux = bus.in1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 2'd0;
            r_ptr       <= 2'd0;
            r_grant     <= 4'b0000;
            r_hold      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_hold  <= w_hold_nxt;

            // Data is captured only from an owner that is still asking for
            // the bus; otherwise out keeps its last word and is flagged stale.
            if ((r_state == ST_GRANT) && w_owner_req) begin
                r_out       <= w_mux;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.select    = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux41_rr_arbiter
// Description : Directed self-checking bench for mux41_rr_arbiter
//               (WIDTH=4, MAX_HOLD=4). Each step drives req/rst, queues the
//               outputs expected after the next rising edge and checks them
//               against the DUT after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux41_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    mux41_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux41_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       g;
        logic [1:0]       s;
        logic [WIDTH-1:0] o;
        logic             v;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check_one(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs required after the
    // coming rising edge, then compare once that edge has passed.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic [WIDTH-1:0] eo, input logic ev,
                        input string tag);
        exp_t e;
        rst     = r;
        bus.req = rq;
        e.g = eg; e.s = es; e.o = eo; e.v = ev; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            check_one({e.tag, ".grant"},     {4'h0, bus.grant},     {4'h0, e.g});
            check_one({e.tag, ".select"},    {6'h0, bus.select},    {6'h0, e.s});
            check_one({e.tag, ".out"},       {4'h0, bus.out},       {4'h0, e.o});
            check_one({e.tag, ".out_valid"}, {7'h0, bus.out_valid}, {7'h0, e.v});
        end
    endtask

    logic [WIDTH-1:0] data [4];
    logic [3:0]       v3;

    initial begin
        data[0] = 4'b0001;
        data[1] = 4'b0011;
        data[2] = 4'b0111;
        data[3] = 4'b1111;
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.in1 = data[0];
        bus.in2 = data[1];
        bus.in3 = data[2];
        bus.in4 = data[3];
        #2;

        // Reset held with every request active
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 4'h0, 1'b0, "rst0");
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 4'h0, 1'b0, "rst1");
        step(1'b0, 4'b1111, 4'b0001, 2'd0, 4'h0, 1'b0, "first_grant");

        // Round robin with everyone requesting: MAX_HOLD cycles each, no gaps
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < MAX_HOLD - 1; c++)
                step(1'b0, 4'b1111, 4'b0001 << k, 2'(k), data[k], 1'b1, "rr_hold");
            step(1'b0, 4'b1111, 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4),
                 data[k], 1'b1, "rr_switch");
        end
        step(1'b0, 4'b1111, 4'b0001, 2'd0, data[0], 1'b1, "rr_wrap");

        // Early release and wrap from in4 back to in1
        step(1'b0, 4'b1000, 4'b1000, 2'd3, data[0], 1'b0, "to_in4");
        step(1'b0, 4'b1001, 4'b1000, 2'd3, data[3], 1'b1, "in4_hold");
        step(1'b0, 4'b0001, 4'b0001, 2'd0, data[3], 1'b0, "wrap_in1");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, data[3], 1'b0, "idle0");

        // Single requester in2 (ptr is 1 here)
        step(1'b0, 4'b0010, 4'b0010, 2'd1, data[3], 1'b0, "single_grant");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, data[1], 1'b1, "single_d0");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, data[1], 1'b1, "single_d1");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, data[1], 1'b1, "single_d2");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, data[1], 1'b0, "single_idle");

        // ptr must now be 2: in3 beats in1 and in2
        step(1'b0, 4'b0111, 4'b0100, 2'd2, data[1], 1'b0, "ptr2_grant");

        // Saturation: only in3 requests, data changes each cycle
        for (int j = 0; j < 10; j++) begin
            v3 = 4'(j + 5);
            bus.in3 = v3;
            step(1'b0, 4'b0100, 4'b0100, 2'd2, v3, 1'b1, "sat_hold");
        end
        bus.in3 = data[2];
        step(1'b0, 4'b0101, 4'b0001, 2'd0, data[2], 1'b1, "sat_preempt");

        // Back to in3, then reset mid-grant
        step(1'b0, 4'b0100, 4'b0100, 2'd2, data[2], 1'b0, "regrant_in3");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, data[2], 1'b1, "in3_valid");
        step(1'b1, 4'b0100, 4'b0000, 2'd0, 4'h0,    1'b0, "mid_rst");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 4'h0,    1'b0, "post_rst_grant");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, data[2], 1'b1, "post_rst_data");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, data[2], 1'b0, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 word mux between four requesters (ports in1..in4).
- Registers the mux select, issues a one-hot grant, and produces a registered, valid-qualified output word.
- Sits in front of the exp1 mux datapath so that several sources can time-share a single 4-bit output bus without conflict.

Parameters:
WIDTH, 4, data width of in1..in4 and out
MAX_HOLD, 4, max consecutive cycles a grant is held while other requests are pending (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  4  request per source; bit0=in1 ... bit3=in4
in1  input  WIDTH  source 0 data
in2  input  WIDTH  source 1 data
in3  input  WIDTH  source 2 data
in4  input  WIDTH  source 3 data
select  output  2  registered mux select (00=in1, 01=in2, 10=in3, 11=in4)
grant  output  4  registered one-hot grant; 0 when idle
out  output  WIDTH  registered muxed data
out_valid  output  1  out carries data from a granted, still-requesting source

Behaviour:
- Single clock domain. Reset is synchronous and active-high (clk, rst); all state changes occur on the rising edge of clk.
- Reset values: state=IDLE, grant=0000, select=00, out=0, out_valid=0, ptr=0, hold_cnt=0. Reset mid-grant drops the grant at that edge; nothing survives reset.
- ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4 (wrap 3->0).
- IDLE:
  - req=0000 -> stay in IDLE; outputs hold.
  - Any req bit set -> the first set bit in search order from ptr wins. Next edge: grant=onehot(win), select=win, hold_cnt=1, state=GRANT.
  - Grant latency is 1 cycle from a req sampled high.
- GRANT (current index s=select):
  - Release when req[s]=0, or when hold_cnt==MAX_HOLD and (req & ~onehot(s))!=0.
  - On release, ptr<=s+1 mod 4 and the winner is searched from s+1 on the same edge. Another pending request is granted back-to-back with no idle cycle and hold_cnt=1. If nothing is pending: state=IDLE, grant=0000, select holds.
  - No release and hold_cnt<MAX_HOLD -> hold_cnt+1.
  - No release and hold_cnt==MAX_HOLD with no other request -> keep grant; hold_cnt saturates at MAX_HOLD.
  - req[s] is sampled each cycle; the grant never persists more than 1 cycle after req[s] falls.
- Data path:
  - At each edge, if state==GRANT and req[s]==1: out<=in[s], out_valid<=1.
  - Otherwise out_valid<=0 and out holds its last value.
  - Data latency: in[s] sampled at edge k appears on out after edge k. The first valid word appears 2 cycles after req rises.
- Simultaneous events:
  - A new req that rises on the same edge the current owner releases takes part in that edge's arbitration.
  - Requests from a non-owner never preempt before MAX_HOLD.
- Invariants: grant is one-hot or zero; when grant!=0, grant==onehot(select); out_valid implies grant!=0 on the previous cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> grant=0000, select=00, out=0000, out_valid=0. After release, grant=0001 one cycle later.
- Single requester: in2=0011, req=0010 held 3 cycles then 0000 -> grant=0010, select=01. out_valid=1 with out=0011 for 3 cycles. Return to IDLE with grant=0000 after req drops; ptr=2.
- Round robin: in1=0001, in2=0011, in3=0111, in4=1111, req=1111 held with MAX_HOLD=4 -> grants 0001,0010,0100,1000,0001 in turn, 4 cycles each with no gaps. out follows 0001,0011,0111,1111.
- Early release and wrap: owner in4 (select=11) drops req while req=0001 -> next edge grant=0001, select=00; ptr wraps to 0.
- Saturation: only req[2] high for 10 cycles -> grant=0100 continuously, hold_cnt stays at 4. When req[0] rises, grant moves to 0001 on the next edge.
- Reset mid-operation: assert rst while grant=0100 and out_valid=1 -> next edge all outputs at reset values. With req=0100 still high after rst deasserts, re-grant occurs in 1 cycle.
